// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register:
// op codes, burst FSM states and the burst-count width helper.
package univ_shift_reg_pkg;

  localparam logic [2:0] OP_HOLD  = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_SHL   = 3'd2;
  localparam logic [2:0] OP_SHR   = 3'd3;
  localparam logic [2:0] OP_ROL   = 3'd4;
  localparam logic [2:0] OP_ROR   = 3'd5;
  localparam logic [2:0] OP_ASR   = 3'd6;
  localparam logic [2:0] OP_BURST = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Bits needed to hold a count of 0..w inclusive.
  function automatic int calc_cw(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/univ_shift_reg_shift_burst_ctrl.sv
// Burst controller: IDLE/RUN FSM, saturating down-counter, busy/done.
// Ports: clk, reset, start (burst request), cnt -> shift_en, busy, done.
module shift_burst_ctrl
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CW = calc_cw(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] cnt,
  output logic          shift_en,
  output logic          busy,
  output logic          done
);

  localparam logic [CW-1:0] WMAX = CW'(WIDTH);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic [CW-1:0] n;

  // Requests longer than the register saturate to a full flush.
  assign n = (cnt > WMAX) ? WMAX : cnt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (n == '0) begin
            done_d = 1'b1;
          end else begin
            cnt_d   = n;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign shift_en = (state_q == ST_RUN);
  assign busy     = (state_q == ST_RUN);
  assign done     = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: load, shifts, rotates, burst serializer.
// Ports: clk, reset, op, d, sin_l, sin_r, cnt -> q, so_lsb, so_msb, busy, done.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CW = calc_cw(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [CW-1:0]    cnt,
  output logic [WIDTH-1:0] q,
  output logic             so_lsb,
  output logic             so_msb,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             shift_en;
  logic             start;

  // Only meaningful while idle; the controller ignores it in RUN.
  assign start = (op == OP_BURST);

  shift_burst_ctrl #(
    .WIDTH (WIDTH)
  ) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .cnt      (cnt),
    .shift_en (shift_en),
    .busy     (busy),
    .done     (done)
  );

  always_comb begin
    q_d = q_q;
    if (shift_en) begin
      q_d = {sin_l, q_q[WIDTH-1:1]};
    end else begin
      case (op)
        OP_LOAD: q_d = d;
        OP_SHL:  q_d = {q_q[WIDTH-2:0], sin_r};
        OP_SHR:  q_d = {sin_l, q_q[WIDTH-1:1]};
        OP_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        OP_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
        OP_ASR:  q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        default: q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q      = q_q;
  assign so_lsb = q_q[0];
  assign so_msb = q_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8).
// Each step is one rising edge; outputs are checked 1ns after it.
module tb_univ_shift_reg;
  import univ_shift_reg_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] op;
  logic [7:0] d;
  logic       sin_l;
  logic       sin_r;
  logic [3:0] cnt;
  logic [7:0] q;
  logic       so_lsb;
  logic       so_msb;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;

  univ_shift_reg #(
    .WIDTH (8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .op     (op),
    .d      (d),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .cnt    (cnt),
    .q      (q),
    .so_lsb (so_lsb),
    .so_msb (so_msb),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    op    = OP_HOLD;
    d     = '0;
    sin_l = 1'b0;
    sin_r = 1'b0;
    cnt   = '0;
    #2;
    step();
    chk("rst_q", q, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_lsb", so_lsb, 1'b0);
    chk("rst_msb", so_msb, 1'b0);
    reset = 1'b0;

    op = OP_LOAD; d = 8'hA5; step();
    chk("load", q, 8'hA5);
    chk("load_msb", so_msb, 1'b1);
    op = OP_SHL; sin_r = 1'b1; step();
    chk("shl", q, 8'h4B);
    op = OP_SHR; sin_l = 1'b0; step();
    chk("shr", q, 8'h25);
    op = OP_HOLD; step();
    chk("hold", q, 8'h25);
    op = OP_LOAD; d = 8'h81; step();
    op = OP_ROL; step();
    chk("rol", q, 8'h03);
    op = OP_LOAD; d = 8'h81; step();
    op = OP_ROR; step();
    chk("ror", q, 8'hC0);
    op = OP_LOAD; d = 8'h90; step();
    op = OP_ASR; step();
    chk("asr", q, 8'hC8);

    // burst of 4 from A5, LOAD driven during RUN must be ignored
    op = OP_LOAD; d = 8'hA5; step();
    op = OP_BURST; cnt = 4'd4; sin_l = 1'b0; step();
    chk("b4_e0_q", q, 8'hA5);
    chk("b4_e0_busy", busy, 1'b1);
    chk("b4_e0_done", done, 1'b0);
    op = OP_LOAD; d = 8'hFF;
    chk("b4_so1", so_lsb, 1'b1);
    step();
    chk("b4_busy1", busy, 1'b1);
    chk("b4_q1", q, 8'h52);
    chk("b4_so2", so_lsb, 1'b0);
    step();
    chk("b4_busy2", busy, 1'b1);
    chk("b4_so3", so_lsb, 1'b1);
    step();
    chk("b4_busy3", busy, 1'b1);
    chk("b4_done3", done, 1'b0);
    chk("b4_so4", so_lsb, 1'b0);
    step();
    chk("b4_q", q, 8'h0A);
    chk("b4_busy4", busy, 1'b0);
    chk("b4_done", done, 1'b1);
    op = OP_HOLD; step();
    chk("b4_done_end", done, 1'b0);
    chk("b4_q_end", q, 8'h0A);

    // zero-length burst
    op = OP_BURST; cnt = 4'd0; step();
    chk("b0_busy", busy, 1'b0);
    chk("b0_done", done, 1'b1);
    chk("b0_q", q, 8'h0A);
    op = OP_HOLD; step();
    chk("b0_done_end", done, 1'b0);

    // saturating burst: 15 -> 8 shifts of sin_l=1
    op = OP_LOAD; d = 8'h5A; step();
    op = OP_BURST; cnt = 4'd15; sin_l = 1'b1; step();
    chk("b15_e0_busy", busy, 1'b1);
    op = OP_HOLD;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("b15_busy", busy, 1'b1);
    end
    step();
    chk("b15_q", q, 8'hFF);
    chk("b15_busy_end", busy, 1'b0);
    chk("b15_done", done, 1'b1);

    // back-to-back: second burst accepted in the done cycle
    op = OP_LOAD; d = 8'h03; step();
    op = OP_BURST; cnt = 4'd1; sin_l = 1'b0; step();
    chk("bb1_busy", busy, 1'b1);
    step();
    chk("bb1_q", q, 8'h01);
    chk("bb1_done", done, 1'b1);
    cnt = 4'd2; sin_l = 1'b1; step();
    chk("bb2_busy", busy, 1'b1);
    chk("bb2_done", done, 1'b0);
    chk("bb2_q0", q, 8'h01);
    op = OP_HOLD; step();
    chk("bb2_q1", q, 8'h80);
    step();
    chk("bb2_q", q, 8'hC0);
    chk("bb2_done2", done, 1'b1);
    step();
    chk("bb2_done_end", done, 1'b0);

    // reset mid-burst
    op = OP_LOAD; d = 8'hFF; step();
    op = OP_BURST; cnt = 4'd6; sin_l = 1'b0; step();
    op = OP_HOLD; step(); step();
    chk("rb_q2", q, 8'h3F);
    reset = 1'b1; step();
    chk("rb_q", q, 8'h00);
    chk("rb_busy", busy, 1'b0);
    chk("rb_done", done, 1'b0);
    reset = 1'b0; step();
    chk("rb_nodone", done, 1'b0);
    op = OP_LOAD; d = 8'h3C; step();
    chk("rb_load", q, 8'h3C);
    chk("rb_load_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register, the successor to the fixed 4-bit load/shift register. It provides a WIDTH-bit register with parallel load, logical/arithmetic shifts and rotates in both directions, and serial inputs at both ends. A self-timed burst mode shifts a programmed number of bits out of the LSB with busy/done handshake. It serves as a general serializer/deserializer and bit-manipulation stage in the exp datapaths.

## Interface
- WIDTH, 8, register width in bits; legal range 2..64
- CW, $clog2(WIDTH+1), width of burst count input (localparam, not overridable)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- op  in  3  operation select (encodings under Operation); sampled every edge while idle
- d  in  WIDTH  parallel load data
- sin_l  in  1  serial input entering at MSB (right shifts, burst)
- sin_r  in  1  serial input entering at LSB (left shifts)
- cnt  in  CW  burst length in bits; sampled only on the burst-accept edge
- q  out  WIDTH  register contents
- so_lsb  out  1  q[0], combinational from q
- so_msb  out  1  q[WIDTH-1], combinational from q
- busy  out  1  high while a burst is in progress
- done  out  1  one-cycle pulse after burst completion

## Operation
- Encodings: 0 HOLD; 1 LOAD q<=d; 2 SHL q<={q[W-2:0],sin_r}; 3 SHR q<={sin_l,q[W-1:1]}; 4 ROL q<={q[W-2:0],q[W-1]}; 5 ROR q<={q[0],q[W-1:1]}; 6 ASR q<={q[W-1],q[W-1:1]}; 7 BURST.
- FSM states: IDLE, RUN. Reset -> IDLE.
- IDLE: ops 0-6 execute on each edge. Op 7 is the burst accept. Let n = min(cnt, WIDTH), with cnt > WIDTH saturating to WIDTH. If n=0, stay IDLE and assert done next cycle with no shift. Otherwise load the internal counter with n, go to RUN, and leave q unchanged on the accept edge.
- RUN: each edge performs SHR (sin_l in at MSB, old q[0] leaves via so_lsb) and decrements the counter. On the edge where the counter goes 1->0, return to IDLE and pulse done. While in RUN, op, d and cnt are ignored.
- done: high exactly one cycle, never coincident with busy=1. A new op 7 presented in the done cycle is accepted normally.
- reset: overrides everything, including mid-burst. q=0, busy=0, done=0, counter=0, state IDLE. No done pulse is generated for an aborted burst.

## Timing
- Ops 0-6: single-cycle latency; q reflects the op after the sampling edge.
- Burst of n bits accepted at edge E0: busy=1 from E0 through En; shifts occur at E1..En; busy=0 and done=1 after En; done=0 after En+1. Total occupancy is n+1 edges.
- Bit presented on so_lsb in the cycle before Ek is the bit shifted out at Ek. The first bit out is q[0] as held after E0.
- All outputs are registered except so_lsb and so_msb, which are pure wiring from q.
- Reset values: q=0, so_lsb=0, so_msb=0, busy=0, done=0.

## Structure
- Package univ_shift_reg_pkg holds: op encoding constants OP_HOLD..OP_BURST, FSM state encoding ST_IDLE/ST_RUN, and the CW computation function.
- One sub-module is natural: shift_burst_ctrl. It contains the FSM, the down-counter, saturation logic, and the busy/done generation. It outputs a shift-enable to the datapath.
- The datapath mux stays in the top module.

## Test plan
- Reset then LOAD: WIDTH=8, reset high one edge -> q=00000000, busy=0, done=0. LOAD d=8'hA5 -> q=8'hA5 after one edge.
- Shifts: from q=8'hA5, apply in turn with one edge each:
  - SHL with sin_r=1 -> 8'h4B
  - SHR with sin_l=0 -> 8'h25
  - ROL from 8'h81 -> 8'h03
  - ROR from 8'h81 -> 8'hC0
  - ASR from 8'h90 -> 8'hC8
- Burst: q=8'hA5, op=7, cnt=4, sin_l=0. so_lsb sequence is 1,0,1,0. busy is high for 5 edges; final q=8'h0A; done is high for exactly one cycle. op=LOAD driven during RUN has no effect.
- Burst boundaries:
  - cnt=0: q unchanged, busy never high, done pulses after one edge.
  - cnt=15 with WIDTH=8: saturates to 8 shifts, q becomes all sin_l.
- Back-to-back bursts: op=7 presented in the done cycle is accepted. busy rises on that edge and there is no idle gap.
- Reset mid-burst: reset asserted after 2 of 6 shifts -> q=0, busy=0, and no done pulse. The next op=LOAD works normally.
